// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file for the multi-cycle RV32I core.
// Serves Zicsr write/set/clear accesses, captures trap state and executes mret.
// Reads and the invalid flag are combinational; all state updates on posedge clk.
// Optional feature macro CSR_COUNTERS_EN adds the 64-bit mcycle/cycle counter.
module csr_file #(
   parameter logic [31:0] HART_ID   = 32'h0,
   parameter logic [31:0] MTVEC_RST = 32'h0000_0004
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] addr,
   input  logic [31:0] bus,
   output logic [31:0] csr_out,
   input  logic        read,
   input  logic        write,
   input  logic [1:0]  write_type,
   input  logic        trap,
   input  logic [4:0]  trap_cause,
   input  logic        ret,
   output logic        invalid
);

   logic        mstatus_mie;
   logic        mstatus_mpie;
   logic [31:0] mie_q;
   logic [31:0] mtvec_q;
   logic [31:0] mscratch_q;
   logic [31:0] mepc_q;
   logic [31:0] mcause_q;
   logic [31:0] mtval_q;
`ifdef CSR_COUNTERS_EN
   logic [63:0] cycle_q;
`endif

   logic [31:0] cur_val;
   logic        implemented;
   logic [31:0] new_val;
   logic        do_write;

   // Current value at addr, plus whether addr names an implemented CSR
   always_comb begin
      cur_val     = '0;
      implemented = 1'b1;
      case (addr)
         12'h300: cur_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
         12'h301: cur_val = 32'h4000_0100;
         12'h304: cur_val = mie_q;
         12'h305: cur_val = mtvec_q;
         12'h340: cur_val = mscratch_q;
         12'h341: cur_val = mepc_q;
         12'h342: cur_val = mcause_q;
         12'h343: cur_val = mtval_q;
         12'h344: cur_val = '0;
         12'hF11, 12'hF12, 12'hF13: cur_val = '0;
         12'hF14: cur_val = HART_ID;
`ifdef CSR_COUNTERS_EN
         12'hB00, 12'hC00: cur_val = cycle_q[31:0];
         12'hB80, 12'hC80: cur_val = cycle_q[63:32];
`endif
         default: implemented = 1'b0;
      endcase
   end

   // Output read data, illegal-access flag and the read-modify-write result
   always_comb begin
      csr_out  = read ? cur_val : '0;
      invalid  = (read | write) & (~implemented | (write & (addr[11:10] == 2'b11)));
      do_write = write & ~invalid & ~trap;
      case (write_type)
         2'b01:   new_val = bus;
         2'b10:   new_val = cur_val | bus;
         2'b11:   new_val = cur_val & ~bus;
         default: new_val = cur_val;
      endcase
   end

   // CSR state: trap beats everything; within a non-trap cycle mret overrides a write to mstatus
   always_ff @(posedge clk) begin
      if (reset) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_q        <= '0;
         mtvec_q      <= {MTVEC_RST[31:2], 2'b00};
         mscratch_q   <= '0;
         mepc_q       <= '0;
         mcause_q     <= '0;
         mtval_q      <= '0;
      end else if (trap) begin
         mepc_q       <= {bus[31:2], 2'b00};
         mcause_q     <= {27'b0, trap_cause};
         mtval_q      <= '0;
         mstatus_mpie <= mstatus_mie;
         mstatus_mie  <= 1'b0;
      end else begin
         if (do_write) begin
            case (addr)
               12'h300: begin
                  mstatus_mie  <= new_val[3];
                  mstatus_mpie <= new_val[7];
               end
               12'h304: mie_q      <= new_val & 32'h0000_0888;
               12'h305: mtvec_q    <= {new_val[31:2], 2'b00};
               12'h340: mscratch_q <= new_val;
               12'h341: mepc_q     <= {new_val[31:2], 2'b00};
               12'h342: mcause_q   <= new_val;
               12'h343: mtval_q    <= new_val;
               default: ;
            endcase
         end
         if (ret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
         end
      end
   end

`ifdef CSR_COUNTERS_EN
   // Free-running cycle counter; a write to either half replaces it and skips that cycle's increment
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q <= '0;
      end else if (do_write && addr == 12'hB00) begin
         cycle_q[31:0] <= new_val;
      end else if (do_write && addr == 12'hB80) begin
         cycle_q[63:32] <= new_val;
      end else begin
         cycle_q <= cycle_q + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: table-driven bench for csr_file with an expected-value scoreboard.
module tb_csr_file;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] addr;
   logic [31:0] bus;
   logic [31:0] csr_out;
   logic        read;
   logic        write;
   logic [1:0]  write_type;
   logic        trap;
   logic [4:0]  trap_cause;
   logic        ret;
   logic        invalid;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  wt;
      logic [11:0] a;
      logic [31:0] b;
      logic        tr;
      logic [4:0]  c;
      logic        rt;
      logic [31:0] eo;
      logic        ei;
   } vec_t;

   typedef struct {
      logic [31:0] eo;
      logic        ei;
      int          id;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   csr_file #(.HART_ID(32'h0000_0005), .MTVEC_RST(32'h0000_0004)) dut (
      .clk(clk), .reset(reset), .addr(addr), .bus(bus), .csr_out(csr_out),
      .read(read), .write(write), .write_type(write_type), .trap(trap),
      .trap_cause(trap_cause), .ret(ret), .invalid(invalid)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] wt,
                               input logic [11:0] a, input logic [31:0] b, input logic tr,
                               input logic [4:0] c, input logic rt,
                               input logic [31:0] eo, input logic ei);
      vec_t v;
      v.rd = rd; v.wr = wr; v.wt = wt; v.a = a; v.b = b;
      v.tr = tr; v.c = c; v.rt = rt; v.eo = eo; v.ei = ei;
      return v;
   endfunction

   task automatic check_out();
      exp_t e;
      e = sb.pop_front();
      tests++;
      if (csr_out !== e.eo || invalid !== e.ei) begin
         fails++;
         $display("FAIL vec%0d: csr_out=%h invalid=%b, expected csr_out=%h invalid=%b",
                  e.id, csr_out, invalid, e.eo, e.ei);
      end
   endtask

   // drive one vector for one cycle, scoreboard its expectation, sample mid-cycle
   task automatic apply(input vec_t v, input int id);
      exp_t e;
      @(negedge clk);
      read = v.rd; write = v.wr; write_type = v.wt; addr = v.a; bus = v.b;
      trap = v.tr; trap_cause = v.c; ret = v.rt;
      e.eo = v.eo; e.ei = v.ei; e.id = id;
      sb.push_back(e);
      #2;
      check_out();
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] eo, input logic ei, input int id);
      apply(mk(1'b1, 1'b0, 2'b00, a, '0, 1'b0, 5'd0, 1'b0, eo, ei), id);
   endtask

   task automatic wr(input logic [1:0] wt, input logic [11:0] a, input logic [31:0] b,
                     input logic ei, input int id);
      apply(mk(1'b0, 1'b1, wt, a, b, 1'b0, 5'd0, 1'b0, 32'h0, ei), id);
   endtask

   initial begin
      reset = 1'b1; read = 1'b0; write = 1'b0; write_type = 2'b00; addr = '0;
      bus = '0; trap = 1'b0; trap_cause = '0; ret = 1'b0;

      // reset state: outputs idle with no strobes
      repeat (2) @(posedge clk);
      apply(mk(0, 0, 2'b00, 12'h305, 32'h0, 0, 5'd0, 0, 32'h0, 1'b0), 0);
      @(negedge clk);
      reset = 1'b0;

      tbl.push_back(mk(1, 0, 2'b00, 12'h305, 32'h0,        0, 5'd0,  0, 32'h0000_0004, 0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h301, 32'h0,        0, 5'd0,  0, 32'h4000_0100, 0));
      tbl.push_back(mk(0, 1, 2'b01, 12'h340, 32'hDEADBEEF, 0, 5'd0,  0, 32'h0,         0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h340, 32'h0,        0, 5'd0,  0, 32'hDEADBEEF,  0));
      tbl.push_back(mk(0, 1, 2'b10, 12'h340, 32'h1,        0, 5'd0,  0, 32'h0,         0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h340, 32'h0,        0, 5'd0,  0, 32'hDEADBEEF,  0));
      tbl.push_back(mk(0, 1, 2'b11, 12'h340, 32'hF0000000, 0, 5'd0,  0, 32'h0,         0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h340, 32'h0,        0, 5'd0,  0, 32'h0EADBEEF,  0));
      tbl.push_back(mk(0, 1, 2'b01, 12'h300, 32'h8,        0, 5'd0,  0, 32'h0,         0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h300, 32'h0,        0, 5'd0,  0, 32'h0000_1808, 0));
      tbl.push_back(mk(0, 0, 2'b00, 12'h000, 32'h104,      1, 5'd2,  0, 32'h0,         0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h341, 32'h0,        0, 5'd0,  0, 32'h0000_0104, 0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h342, 32'h0,        0, 5'd0,  0, 32'h0000_0002, 0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h300, 32'h0,        0, 5'd0,  0, 32'h0000_1880, 0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h341, 32'h0,        0, 5'd0,  1, 32'h0000_0104, 0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h300, 32'h0,        0, 5'd0,  0, 32'h0000_1888, 0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h7C0, 32'h0,        0, 5'd0,  0, 32'h0,         1));
      tbl.push_back(mk(0, 1, 2'b01, 12'h7C0, 32'h1,        0, 5'd0,  0, 32'h0,         1));
      tbl.push_back(mk(1, 1, 2'b01, 12'hF14, 32'hFFFFFFFF, 0, 5'd0,  0, 32'h0000_0005, 1));
      tbl.push_back(mk(1, 0, 2'b00, 12'hF14, 32'h0,        0, 5'd0,  0, 32'h0000_0005, 0));
      tbl.push_back(mk(1, 0, 2'b00, 12'hF11, 32'h0,        0, 5'd0,  0, 32'h0,         0));
      tbl.push_back(mk(0, 1, 2'b10, 12'h341, 32'h200,      1, 5'd5,  0, 32'h0,         0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h341, 32'h0,        0, 5'd0,  0, 32'h0000_0200, 0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h342, 32'h0,        0, 5'd0,  0, 32'h0000_0005, 0));
      tbl.push_back(mk(0, 1, 2'b01, 12'h305, 32'h12345677, 0, 5'd0,  0, 32'h0,         0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h305, 32'h0,        0, 5'd0,  0, 32'h12345674,  0));
      tbl.push_back(mk(0, 1, 2'b01, 12'h304, 32'hFFFFFFFF, 0, 5'd0,  0, 32'h0,         0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h304, 32'h0,        0, 5'd0,  0, 32'h0000_0888, 0));
      tbl.push_back(mk(0, 1, 2'b01, 12'h343, 32'hCAFE,     0, 5'd0,  0, 32'h0,         0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h343, 32'h0,        0, 5'd0,  0, 32'h0000_CAFE, 0));
      tbl.push_back(mk(0, 0, 2'b00, 12'h000, 32'h1003,     1, 5'd11, 0, 32'h0,         0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h343, 32'h0,        0, 5'd0,  0, 32'h0,         0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h341, 32'h0,        0, 5'd0,  0, 32'h0000_1000, 0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h300, 32'h0,        0, 5'd0,  0, 32'h0000_1800, 0));
      tbl.push_back(mk(0, 1, 2'b01, 12'h344, 32'hFFFF,     0, 5'd0,  0, 32'h0,         0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h344, 32'h0,        0, 5'd0,  0, 32'h0,         0));
      tbl.push_back(mk(0, 1, 2'b01, 12'h301, 32'h0,        0, 5'd0,  0, 32'h0,         0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h301, 32'h0,        0, 5'd0,  0, 32'h4000_0100, 0));
      tbl.push_back(mk(0, 1, 2'b00, 12'h340, 32'h0,        0, 5'd0,  0, 32'h0,         0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h340, 32'h0,        0, 5'd0,  0, 32'h0EADBEEF,  0));
      tbl.push_back(mk(0, 1, 2'b01, 12'h341, 32'h7,        0, 5'd0,  0, 32'h0,         0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h341, 32'h0,        0, 5'd0,  0, 32'h0000_0004, 0));
      tbl.push_back(mk(0, 0, 2'b00, 12'h341, 32'h0,        0, 5'd0,  1, 32'h0,         0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h300, 32'h0,        0, 5'd0,  0, 32'h0000_1880, 0));
      tbl.push_back(mk(0, 1, 2'b11, 12'h300, 32'hFFFFFFFF, 0, 5'd0,  0, 32'h0,         0));
      tbl.push_back(mk(1, 0, 2'b00, 12'h300, 32'h0,        0, 5'd0,  0, 32'h0000_1800, 0));
`ifndef CSR_COUNTERS_EN
      tbl.push_back(mk(1, 0, 2'b00, 12'hC00, 32'h0,        0, 5'd0,  0, 32'h0,         1));
      tbl.push_back(mk(0, 1, 2'b01, 12'hB00, 32'h5,        0, 5'd0,  0, 32'h0,         1));
      tbl.push_back(mk(1, 0, 2'b00, 12'hC80, 32'h0,        0, 5'd0,  0, 32'h0,         1));
`endif

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i + 1);

      // mid-run reset restores reset values
      @(negedge clk);
      read = 1'b0; write = 1'b0; trap = 1'b0; ret = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      rd(12'h340, 32'h0,           1'b0, 100);
      rd(12'h305, 32'h0000_0004,   1'b0, 101);
      rd(12'h300, 32'h0000_1800,   1'b0, 102);
      rd(12'h341, 32'h0,           1'b0, 103);
      rd(12'h304, 32'h0,           1'b0, 104);

`ifdef CSR_COUNTERS_EN
      // counter: write holds the count for one cycle, then it advances every cycle
      wr(2'b01, 12'hB00, 32'd100, 1'b0, 200);
      rd(12'hB00, 32'd100, 1'b0, 201);
      rd(12'hB00, 32'd101, 1'b0, 202);
      rd(12'hC00, 32'd102, 1'b0, 203);
      rd(12'hC80, 32'd0,   1'b0, 204);
      wr(2'b01, 12'hB80, 32'd7, 1'b0, 205);
      rd(12'hC80, 32'd7,   1'b0, 206);
      rd(12'hC00, 32'd104, 1'b0, 207);
      wr(2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0, 208);
      rd(12'hB00, 32'hFFFF_FFFF, 1'b0, 209);
      rd(12'hC80, 32'd8,   1'b0, 210);
      rd(12'hC00, 32'd1,   1'b0, 211);
      wr(2'b01, 12'hC00, 32'd9, 1'b1, 212);
      rd(12'hC00, 32'd3,   1'b0, 213);
`endif

      @(negedge clk);
      read = 1'b0; write = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
